// File: rtl/case_conv_pkg.sv
// Shared types and byte-range constants for the streaming ASCII case converter.
package case_conv_pkg;

    localparam int unsigned CC_BYTE_W = 8;

    typedef enum logic [1:0] {
        CC_PASS   = 2'd0,
        CC_UPPER  = 2'd1,
        CC_LOWER  = 2'd2,
        CC_TOGGLE = 2'd3
    } cc_mode_e;

    typedef enum logic {
        CC_IDLE   = 1'b0,
        CC_IN_PKT = 1'b1
    } cc_state_e;

    localparam logic [CC_BYTE_W-1:0] CC_UPPER_LO = 8'h41;
    localparam logic [CC_BYTE_W-1:0] CC_UPPER_HI = 8'h5A;
    localparam logic [CC_BYTE_W-1:0] CC_LOWER_LO = 8'h61;
    localparam logic [CC_BYTE_W-1:0] CC_LOWER_HI = 8'h7A;
    localparam logic [CC_BYTE_W-1:0] CC_CASE_BIT = 8'h20;

    function automatic logic cc_in_range(input logic [CC_BYTE_W-1:0] b,
                                         input logic [CC_BYTE_W-1:0] lo,
                                         input logic [CC_BYTE_W-1:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/case_conv_lane.sv
// Single-byte case converter: applies the selected mode to one ASCII byte.
module case_conv_lane
    import case_conv_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] mode,
    output logic [7:0] result,
    output logic       changed
);

    logic is_upper;
    logic is_lower;

    assign is_upper = cc_in_range(data, CC_UPPER_LO, CC_UPPER_HI);
    assign is_lower = cc_in_range(data, CC_LOWER_LO, CC_LOWER_HI);

    // Only letters are ever touched; bit 5 is the case bit.
    always_comb begin
        result = data;
        case (cc_mode_e'(mode))
            CC_UPPER:  if (is_lower) result = data & ~CC_CASE_BIT;
            CC_LOWER:  if (is_upper) result = data | CC_CASE_BIT;
            CC_TOGGLE: if (is_upper || is_lower) result = data ^ CC_CASE_BIT;
            default:   result = data;
        endcase
        changed = (result != data);
    end

endmodule

// File: rtl/case_conv_stream.sv
// Streaming LANES-wide ASCII case converter with per-packet mode and skid buffer.
// Optional conv_count output enabled by defining CASE_CONV_COUNT_EN.
module case_conv_stream
    import case_conv_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_last
`ifdef CASE_CONV_COUNT_EN
    ,
    output logic [31:0]        conv_count
`endif
);

    localparam int unsigned DW = 8 * LANES;
    localparam int unsigned CW = $clog2(LANES + 1);

    cc_state_e        state;
    cc_mode_e         pkt_mode;
    logic [1:0]       cur_mode;
    logic [DW-1:0]    conv_data;
    logic [LANES-1:0] lane_chg;

    logic             skid_valid;
    logic [DW-1:0]    skid_data;
    logic             skid_last;

    logic             accept;
    logic             drain;
    logic             out_free;
    logic             skid_next;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_free  = !out_valid || out_ready;
    assign skid_next = !out_free && (skid_valid || accept);

    // The first beat of a packet converts with the live mode; later beats use the latched one.
    assign cur_mode = (state == CC_IDLE) ? mode : pkt_mode;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        case_conv_lane u_lane (
            .data    (in_data[8*i +: 8]),
            .mode    (cur_mode),
            .result  (conv_data[8*i +: 8]),
            .changed (lane_chg[i])
        );
    end

    // Packet framing FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CC_IDLE;
            pkt_mode <= CC_PASS;
        end else if (accept) begin
            case (state)
                CC_IDLE: begin
                    pkt_mode <= cc_mode_e'(mode);
                    state    <= in_last ? CC_IDLE : CC_IN_PKT;
                end
                CC_IN_PKT: begin
                    if (in_last) state <= CC_IDLE;
                end
                default: state <= CC_IDLE;
            endcase
        end
    end

    // Output register plus skid; in_ready mirrors the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= conv_data;
                    out_last  <= in_last;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= conv_data;
                skid_last  <= in_last;
            end
            in_ready <= !skid_next;
        end
    end

`ifdef CASE_CONV_COUNT_EN
    logic [CW-1:0] chg_cnt;
    logic [CW-1:0] out_nchg;
    logic [CW-1:0] skid_nchg;
    logic [32:0]   cnt_sum;

    always_comb begin
        chg_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            chg_cnt = chg_cnt + CW'(lane_chg[i]);
        end
    end

    assign cnt_sum = {1'b0, conv_count} + 33'(out_nchg);

    // Changed-byte tallies travel with their beat; the counter advances on the output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_nchg   <= '0;
            skid_nchg  <= '0;
            conv_count <= '0;
        end else begin
            if (out_free) begin
                if (skid_valid) out_nchg <= skid_nchg;
                else if (accept) out_nchg <= chg_cnt;
            end else if (accept) begin
                skid_nchg <= chg_cnt;
            end
            if (drain) conv_count <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end
`else
    logic unused_chg;
    logic unused_drain;
    assign unused_chg   = ^lane_chg;
    assign unused_drain = drain;
`endif

endmodule

// File: doc/case_conv_stream.md
# case_conv_stream

Streaming, parametrised successor to the byte-wide ASCII upper-case converter. It accepts LANES ASCII bytes per beat over a valid/ready handshake and applies a per-packet case mode to each byte: pass, upper, lower or toggle. Results are registered, with one cycle of latency and a skid buffer so that full throughput survives output backpressure. It sits between the text-ingest stream and downstream formatting logic.

## Interface
- LANES, default 4: bytes per beat; legal range 1–16.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  case mode: 0 PASS, 1 UPPER, 2 LOWER, 3 TOGGLE. Sampled only on the first beat of a packet.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  8*LANES  input bytes; lane i occupies [8i+7:8i]; lane 0 is first in stream order.
- in_last  in  1  final beat of the packet.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  8*LANES  converted bytes, same lane order as the input.
- out_last  out  1  in_last carried through with its beat.
- conv_count  out  32  bytes changed by conversion. Present only with CASE_CONV_COUNT_EN.

## Operation
- Per-byte rules:
  - Lowercase byte: 0x61–0x7A. Uppercase byte: 0x41–0x5A.
  - UPPER clears bit 5 of lowercase bytes only.
  - LOWER sets bit 5 of uppercase bytes only.
  - TOGGLE inverts bit 5 of any letter.
  - PASS changes nothing.
  - Every other byte is unchanged in every mode, including 0x5B–0x60, 0x7B–0x7F and all bytes ≥0x80.
- Handshake and packet FSM:
  - A beat transfers when valid && ready.
  - FSM states:
    - IDLE: on an accepted beat, latch `mode` into pkt_mode and convert that beat with the new value. Go to IN_PKT unless in_last is set.
    - IN_PKT: convert with pkt_mode and ignore `mode`. Return to IDLE on an accepted beat with in_last set.
  - A single-beat packet (in_last on its first beat) stays in IDLE.
- Buffering:
  - One output register plus one skid register.
  - An accepted beat goes to the output register when it is empty or draining that cycle; otherwise it goes to the skid.
  - The skid moves to the output register when the output drains.
- Upstream rules: once in_valid is asserted it is held, with data, last and mode stable, until accepted. This is upstream's obligation; the block does not check it.

## Timing
- Reset (while rst is high, effective at the next edge):
  - out_valid=0, out_last=0, out_data=0, in_ready=0.
  - FSM=IDLE, skid empty, conv_count=0.
- in_ready:
  - Registered; equals !skid_valid.
  - Goes to 1 on the first edge after rst deasserts.
- Latency: a beat accepted at edge N is on out_data after edge N, provided the output register was empty or draining.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, at most one further beat is accepted (into the skid), then in_ready=0 the next cycle. No beat is dropped or duplicated.
- Simultaneous events:
  - Output drain and skid refill in the same cycle: both take effect.
  - in_last accepted in the same cycle as a new packet's first beat cannot occur, because there is one beat per cycle.
- Reset mid-packet: any packet in flight is discarded, the FSM returns to IDLE, and the next accepted beat starts a new packet.

## Configuration
- CASE_CONV_COUNT_EN defined:
  - conv_count exists.
  - It adds the number of lanes whose output byte differs from the input byte, counted at the output handshake (out_valid && out_ready).
  - It saturates at 0xFFFFFFFF and is cleared only by rst.
- CASE_CONV_COUNT_EN undefined: the port and its logic are absent. Datapath behaviour is identical.

## Structure
- Package case_conv_pkg holds:
  - the mode enum (CC_PASS, CC_UPPER, CC_LOWER, CC_TOGGLE);
  - the FSM state enum (CC_IDLE, CC_IN_PKT);
  - byte-range constants 0x41, 0x5A, 0x61, 0x7A.
- Sub-module case_conv_lane: combinational, one byte in, mode in, one byte out plus a `changed` flag. Instantiated LANES times with a generate loop.

## Test plan
- UPPER, LANES=4, in_data=0x7A_61_5B_40 ("@[az", lane 0 first), in_last=1 → out_data=0x5A_41_5B_40 one cycle later, out_last=1. conv_count=2 if enabled.
- TOGGLE, in_data=0x80_7A_41_61 → 0x80_5A_61_41. Byte 0x80 is untouched.
- Packet-level mode latch: mode=LOWER on beat 0 of a 3-beat packet, then mode switched to UPPER on beats 1–2. Every beat is lowered. The following packet, with mode=UPPER, is uppercased.
- Backpressure: stream 6 beats with out_ready=0 for cycles 2–5.
  - in_ready drops the cycle after the skid fills.
  - The output sequence equals the input sequence, with no loss or duplication.
- Reset mid-packet: assert rst during beat 2 of 4.
  - out_valid=0 and in_ready=0 during reset.
  - After release, a fresh single-beat packet uses the newly sampled mode.
- Saturation (CASE_CONV_COUNT_EN): force conv_count to 0xFFFFFFFE and send 4 changing bytes → conv_count=0xFFFFFFFF.
